// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector: per-channel synchroniser, debounce filter and Moore edge FSM,
// producing mode-qualified rise/fall pulses, sticky event flags and saturating event counters.
module edge_detector_multi #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic [CH-1:0]       strobe,
  input  logic [2*CH-1:0]     mode,
  input  logic [CH-1:0]       clr,
  output logic [CH-1:0]       rise_p,
  output logic [CH-1:0]       fall_p,
  output logic                any_evt,
  output logic [CH-1:0]       evt_flag,
  output logic [CH*CNT_W-1:0] evt_cnt
);

  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ZERO = 2'b00,
    RISE = 2'b01,
    ONE  = 2'b10,
    FALL = 2'b11
  } state_t;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic            sync_s;
    logic            filt_r;
    logic [DB_W-1:0] db_cnt_r;
    state_t          state_r;
    state_t          state_nxt_s;
    logic            pulse_s;
    logic            flag_r;
    logic [CNT_W-1:0] cnt_r;

    if (SYNC_STAGES == 0) begin : g_bypass
      assign sync_s = strobe[g];
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] chain_r;

      // Shift the raw input through the synchroniser chain
      always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
          chain_r <= '0;
        end else begin
          chain_r <= (chain_r << 1) | SYNC_STAGES'(strobe[g]);
        end
      end

      assign sync_s = chain_r[SYNC_STAGES-1];
    end

    // Accept a new level only after it has differed from the filtered level long enough
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        filt_r   <= 1'b0;
        db_cnt_r <= '0;
      end else if (sync_s == filt_r) begin
        db_cnt_r <= '0;
      end else if (db_cnt_r == DB_LAST) begin
        filt_r   <= sync_s;
        db_cnt_r <= '0;
      end else begin
        db_cnt_r <= db_cnt_r + DB_W'(1);
      end
    end

    // Edge FSM next state; it follows the filtered level whatever the mode
    always_comb begin
      state_nxt_s = ZERO;
      case (state_r)
        ZERO:    state_nxt_s = filt_r ? RISE : ZERO;
        RISE:    state_nxt_s = filt_r ? ONE  : FALL;
        ONE:     state_nxt_s = filt_r ? ONE  : FALL;
        FALL:    state_nxt_s = filt_r ? RISE : ZERO;
        default: state_nxt_s = ZERO;
      endcase
    end

    // Edge FSM state register
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        state_r <= ZERO;
      end else begin
        state_r <= state_nxt_s;
      end
    end

    assign rise_p[g] = (state_r == RISE) & mode[2*g];
    assign fall_p[g] = (state_r == FALL) & mode[2*g+1];
    assign pulse_s   = rise_p[g] | fall_p[g];

    // Sticky flag and saturating counter; a pulse coinciding with clr is still recorded
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        flag_r <= 1'b0;
        cnt_r  <= '0;
      end else if (clr[g]) begin
        flag_r <= pulse_s;
        cnt_r  <= CNT_W'(pulse_s);
      end else if (pulse_s) begin
        flag_r <= 1'b1;
        if (cnt_r != CNT_MAX) begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end
    end

    assign evt_flag[g]                = flag_r;
    assign evt_cnt[g*CNT_W +: CNT_W]  = cnt_r;
  end

  assign any_evt = |(rise_p | fall_p);

endmodule
